dds_cordic_sweep: RTL and testbench
===================================

Name: dds_cordic_sweep

Overview:
- Second-generation DDS for the GMSK modulator/test-tone path: phase accumulator plus iterative CORDIC, one rotation per clock, producing signed sin/cos samples.
- Over the first-generation DDS it adds:
  - parametrised phase, output and iteration widths;
  - power-of-two phase wrap;
  - a static phase offset;
  - a sawtooth frequency sweep with an upper limit;
  - a valid/ready output handshake with backpressure.
- Sits between the baseband control registers and the I/Q mixer/DAC formatter.

Parameters:
- PHASE_W, 16, accumulator/angle width; full circle = 2^PHASE_W.
- OUT_W, 8, signed sin/cos output width.
- ITER, 10, CORDIC micro-rotations per sample (1..PHASE_W-2); internal x/y width OUT_W+4, z width PHASE_W.

Ports:
- clk  in  1  reference clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable
- f_word  in  PHASE_W  base frequency control word (phase increment per sample)
- phase_off  in  PHASE_W  phase offset added to the accumulator for the CORDIC angle only (never accumulated)
- sweep_en  in  1  enable frequency sweep
- sweep_step  in  PHASE_W  frequency increment per sample while sweeping
- f_max  in  PHASE_W  sweep upper limit
- sync_clr  in  1  zero the phase and reload the frequency at the next sample boundary
- dout_ready  in  1  downstream accepts sample
- dout_valid  out  1  sample present on sin_dout/cos_dout
- sin_dout  out  OUT_W  signed sine sample
- cos_dout  out  OUT_W  signed cosine sample
- busy  out  1  high in any state other than IDLE

Behaviour:

Reset:
- Reset (async, high) clears: state=IDLE, acc_r=0, freq_r=0, dout_valid=0, sin_dout=0, cos_dout=0, busy=0.
- Reset mid-operation aborts the rotation immediately; no partial sample is ever presented.

FSM states: IDLE, LOAD, ROTATE, HOLD.
- IDLE:
  - freq_r <= f_word every cycle; acc_r <= 0 if sync_clr.
  - en=1 -> LOAD.
- LOAD (1 cycle):
  - angle = acc_r + phase_off, mod 2^PHASE_W.
  - q = angle[PHASE_W-1:PHASE_W-2]; residual = angle with the top two bits cleared.
  - x <= K·(2^(OUT_W-1)-1), with K≈0.60725 pre-scaled; y <= 0; z <= residual; iteration counter i <= 0.
  - -> ROTATE.
- ROTATE (exactly ITER cycles):
  - d = sign(z).
  - x <= x - d·(y>>>i); y <= y + d·(x>>>i); z <= z - d·atan_tab[i].
  - atan_tab[i] = round(atan(2^-i)·2^PHASE_W/(2π)), a constant table.
  - On the last iteration, register the outputs and go to HOLD.
- Quadrant map of (c,s) = (x,y):
  - q=0 -> (cos,sin)=(c,s)
  - q=1 -> (-s,c)
  - q=2 -> (-c,-s)
  - q=3 -> (s,-c)
- Output rounding and saturation:
  - Round x/y to OUT_W and saturate to ±(2^(OUT_W-1)-1); -2^(OUT_W-1) is never output.
  - Accuracy: within ±1 LSB of round((2^(OUT_W-1)-1)·sin/cos(2π·angle/2^PHASE_W)).
  - sin_dout is true sine (not negated).
- HOLD:
  - dout_valid=1; sin_dout/cos_dout and all state are held stable while dout_ready=0.
  - On dout_valid&&dout_ready (the sample boundary):
    - acc_r <= acc_r + freq_r (binary wrap), or 0 if sync_clr.
    - Frequency update:
      - if sync_clr or !sweep_en: freq_r <= f_word;
      - else if freq_r + sweep_step (PHASE_W+1-bit compare) > f_max: freq_r <= f_word;
      - else freq_r <= freq_r + sweep_step.
    - dout_valid drops on the next edge.
    - Next state: en -> LOAD, else IDLE.

Timing:
- First dout_valid appears ITER+2 cycles after the en rising edge is sampled in IDLE.
- With dout_ready tied high, sample period = ITER+2 cycles.

Boundary conditions:
- f_word, phase_off and sweep inputs are sampled only at LOAD/boundary; changes mid-rotation do not affect the current sample.
- en dropped mid-sample: the current sample completes and is handshaken, then IDLE. Outputs keep their last value with dout_valid=0.
- sync_clr pulse shorter than a sample period is honoured only if high at the boundary or in IDLE.
- Sweep wrap uses the unsigned PHASE_W+1-bit sum, so overflow past 2^PHASE_W also reloads f_word.

Test Plan:
- Defaults, phase_off=0, f_word=0x4000, dout_ready=1, en=1 -> (cos,sin)=(127,0),(0,127),(-127,0),(0,-127) repeating ±1 LSB; first valid 12 cycles after en; period 12 cycles.
- f_word=0xC000 -> acc 0x0000,0xC000,0x8000,0x4000; outputs (127,0),(0,-127),(-127,0),(0,127), confirming wrap.
- f_word=0, phase_off=0x2000 -> constant (90,90) ±1; phase_off=0xA000 -> (-90,-90) ±1.
- sweep_en=1, f_word=0x1000, sweep_step=0x1000, f_max=0x3000 -> freq_r 0x1000,0x2000,0x3000,0x1000,...; acc 0,0x1000,0x3000,0x6000,0x7000.
- Backpressure: dout_ready=0 for 5 cycles in HOLD -> dout_valid stays 1, outputs and acc_r unchanged; on ready=1, one handshake, acc advances once.
- rst pulsed during ROTATE -> same-cycle dout_valid=0, sin/cos=0, busy=0. Also: sync_clr held at a boundary -> next sample angle = phase_off, output (127,0) for phase_off=0.

Source files
------------

// File: rtl/dds_cordic_sweep.sv
// Phase-accumulator DDS with one-micro-rotation-per-clock CORDIC, sawtooth
// frequency sweep and a valid/ready output stage that holds under backpressure.
module dds_cordic_sweep #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 8,
    parameter int ITER    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [PHASE_W-1:0]        f_word,
    input  logic [PHASE_W-1:0]        phase_off,
    input  logic                      sweep_en,
    input  logic [PHASE_W-1:0]        sweep_step,
    input  logic [PHASE_W-1:0]        f_max,
    input  logic                      sync_clr,
    input  logic                      dout_ready,
    output logic                      dout_valid,
    output logic signed [OUT_W-1:0]   sin_dout,
    output logic signed [OUT_W-1:0]   cos_dout,
    output logic                      busy
);
    localparam int XW  = OUT_W + 4;
    localparam int IW  = $clog2(ITER + 1);
    localparam int AMP = 2**(OUT_W-1) - 1;
    // x/y carry 4 fraction bits; start vector is K*AMP*16 with K ~= 39797/2^16.
    localparam longint X0_L = (longint'(AMP) * 16 * 39797 + 32768) >>> 16;
    localparam logic signed [XW-1:0]    X0    = XW'(X0_L);
    localparam logic signed [XW:0]      AMP_X = (XW+1)'(AMP);
    localparam logic signed [OUT_W-1:0] AMP_O = OUT_W'(AMP);

    typedef enum logic [1:0] {IDLE, LOAD, ROTATE, HOLD} state_t;

    state_t                    state, state_nxt;
    logic [PHASE_W-1:0]        acc_r, freq_r, angle, atan_i, freq_adv;
    logic [PHASE_W:0]          sweep_sum;
    logic signed [XW-1:0]      x_r, y_r, x_nxt, y_nxt;
    logic signed [PHASE_W-1:0] z_r, z_nxt;
    logic [1:0]                q_r;
    logic [IW-1:0]             i_r;
    logic                      last_iter, fire;
    logic signed [OUT_W-1:0]   c_o, s_o, cos_q, sin_q;

    // Table held at 2^16-per-circle scale, rescaled (with rounding) to PHASE_W.
    function automatic logic [PHASE_W-1:0] atan_tab(input int idx);
        int v;
        int sh;
        case (idx)
            0:  v = 8192;
            1:  v = 4836;
            2:  v = 2555;
            3:  v = 1297;
            4:  v = 651;
            5:  v = 326;
            6:  v = 163;
            7:  v = 81;
            8:  v = 41;
            9:  v = 20;
            10: v = 10;
            11: v = 5;
            12: v = 3;
            13: v = 1;
            14: v = 1;
            default: v = 0;
        endcase
        sh = PHASE_W - 16;
        if (sh >= 0) v = v <<< sh;
        else         v = (v + (1 <<< (-sh - 1))) >>> (-sh);
        return PHASE_W'(v);
    endfunction

    function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] r;
        r = $signed({v[XW-1], v} + (XW+1)'(8)) >>> 4;
        if (r > AMP_X)       return AMP_O;
        else if (r < -AMP_X) return -AMP_O;
        else                 return r[OUT_W-1:0];
    endfunction

    always_comb begin
        angle     = acc_r + phase_off;
        last_iter = (i_r == IW'(ITER - 1));
        fire      = dout_valid && dout_ready;
        atan_i    = atan_tab(int'(i_r));
        if (!z_r[PHASE_W-1]) begin
            x_nxt = x_r - (y_r >>> i_r);
            y_nxt = y_r + (x_r >>> i_r);
            z_nxt = z_r - $signed(atan_i);
        end else begin
            x_nxt = x_r + (y_r >>> i_r);
            y_nxt = y_r - (x_r >>> i_r);
            z_nxt = z_r + $signed(atan_i);
        end
        c_o = rnd_sat(x_nxt);
        s_o = rnd_sat(y_nxt);
        case (q_r)
            2'd0:    begin cos_q = c_o;  sin_q = s_o;  end
            2'd1:    begin cos_q = -s_o; sin_q = c_o;  end
            2'd2:    begin cos_q = -c_o; sin_q = -s_o; end
            default: begin cos_q = s_o;  sin_q = -c_o; end
        endcase
        // Sum kept one bit wider so an overflowing sweep also wraps back to f_word.
        sweep_sum = {1'b0, freq_r} + {1'b0, sweep_step};
        if (sync_clr || !sweep_en || sweep_sum > {1'b0, f_max}) freq_adv = f_word;
        else                                                    freq_adv = sweep_sum[PHASE_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (en) state_nxt = LOAD;
            LOAD:    state_nxt = ROTATE;
            ROTATE:  if (last_iter) state_nxt = HOLD;
            HOLD:    if (fire) state_nxt = en ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc_r      <= '0;
            freq_r     <= '0;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
            q_r        <= '0;
            i_r        <= '0;
            dout_valid <= 1'b0;
            sin_dout   <= '0;
            cos_dout   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    freq_r <= f_word;
                    if (sync_clr) acc_r <= '0;
                end
                LOAD: begin
                    x_r <= X0;
                    y_r <= '0;
                    z_r <= $signed({2'b00, angle[PHASE_W-3:0]});
                    q_r <= angle[PHASE_W-1:PHASE_W-2];
                    i_r <= '0;
                end
                ROTATE: begin
                    x_r <= x_nxt;
                    y_r <= y_nxt;
                    z_r <= z_nxt;
                    i_r <= i_r + IW'(1);
                    if (last_iter) begin
                        sin_dout   <= sin_q;
                        cos_dout   <= cos_q;
                        dout_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (fire) begin
                        dout_valid <= 1'b0;
                        acc_r      <= sync_clr ? '0 : acc_r + freq_r;
                        freq_r     <= freq_adv;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_cordic_sweep.sv
// Bench for dds_cordic_sweep: a phase/frequency model computed with plain
// integer arithmetic and real-valued sin/cos, compared within +-1 LSB.
module tb_dds_cordic_sweep;
    localparam int  PHASE_W = 16;
    localparam int  OUT_W   = 8;
    localparam int  ITER    = 10;
    localparam int  FULL    = 1 << PHASE_W;
    localparam int  AMP     = (1 << (OUT_W-1)) - 1;
    localparam real PI      = 3.14159265358979;

    logic clk = 1'b0;
    logic rst, en, sweep_en, sync_clr, dout_ready;
    logic [PHASE_W-1:0] f_word, phase_off, sweep_step, f_max;
    logic dout_valid, busy;
    logic signed [OUT_W-1:0] sin_dout, cos_dout;

    int total, bad;
    int m_acc, m_freq;

    dds_cordic_sweep #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .ITER(ITER)) dut (
        .clk(clk), .rst(rst), .en(en), .f_word(f_word), .phase_off(phase_off),
        .sweep_en(sweep_en), .sweep_step(sweep_step), .f_max(f_max),
        .sync_clr(sync_clr), .dout_ready(dout_ready), .dout_valid(dout_valid),
        .sin_dout(sin_dout), .cos_dout(cos_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int rnd(real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction
    function automatic int ref_cos(int a);
        return rnd(AMP * $cos(2.0 * PI * real'(a) / real'(FULL)));
    endfunction
    function automatic int ref_sin(int a);
        return rnd(AMP * $sin(2.0 * PI * real'(a) / real'(FULL)));
    endfunction
    function automatic bit near(int a, int e);
        return (a - e) <= 1 && (e - a) <= 1;
    endfunction
    function automatic int cur_angle();
        return (m_acc + int'(phase_off)) % FULL;
    endfunction

    // Phase/frequency advance at a handshake, using the inputs present now.
    task automatic model_boundary();
        int sum;
        sum = m_freq + int'(sweep_step);
        m_acc = sync_clr ? 0 : (m_acc + m_freq) % FULL;
        if (sync_clr || !sweep_en || sum > int'(f_max)) m_freq = int'(f_word);
        else                                            m_freq = sum;
    endtask

    task automatic get_sample(output int c, output int s, output int cyc, output bit to);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!dout_valid && cyc < 200);
        to = !dout_valid;
        c  = int'(cos_dout);
        s  = int'(sin_dout);
    endtask

    task automatic start(input logic [PHASE_W-1:0] f, off, input logic swe,
                         input logic [PHASE_W-1:0] step, fm, input logic rdy);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; sync_clr = 1'b0;
        f_word = f; phase_off = off; sweep_en = swe; sweep_step = step; f_max = fm;
        dout_ready = rdy;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        m_acc = 0;
        m_freq = int'(f);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; sweep_en = 1'b0; dout_ready = 1'b0;
        f_word = '0; phase_off = '0; sweep_step = '0; f_max = '0;
        repeat (2) @(negedge clk);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        total++; if (sin_dout !== '0) begin bad++; $display("FAIL reset_sin got %0d want 0", sin_dout); end
        total++; if (cos_dout !== '0) begin bad++; $display("FAIL reset_cos got %0d want 0", cos_dout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int c, s, cyc, a; bit to;
        start(16'h4000, 16'h0000, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            get_sample(c, s, cyc, to);
            a = cur_angle();
            total++;
            if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
                bad++; $display("FAIL basic k=%0d angle=%h got (%0d,%0d) want (%0d,%0d)+-1", k, a, c, s, ref_cos(a), ref_sin(a));
            end
            total++;
            if (cyc != ITER + 2) begin bad++; $display("FAIL basic_timing k=%0d got %0d cycles want %0d", k, cyc, ITER + 2); end
            model_boundary();
        end
    endtask

    task automatic test_wrap();
        int c, s, cyc, a; bit to;
        start(16'hC000, 16'h0000, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            get_sample(c, s, cyc, to);
            a = cur_angle();
            total++;
            if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
                bad++; $display("FAIL wrap k=%0d angle=%h got (%0d,%0d) want (%0d,%0d)+-1", k, a, c, s, ref_cos(a), ref_sin(a));
            end
            model_boundary();
        end
    endtask

    task automatic test_offset();
        int c, s, cyc, a; bit to;
        start(16'h0000, 16'h2000, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            get_sample(c, s, cyc, to);
            a = cur_angle();
            total++;
            if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
                bad++; $display("FAIL offset k=%0d angle=%h got (%0d,%0d) want (%0d,%0d)+-1", k, a, c, s, ref_cos(a), ref_sin(a));
            end
            model_boundary();
            if (k == 2) phase_off = 16'hA000;
        end
    endtask

    task automatic test_sweep();
        int c, s, cyc, a; bit to;
        start(16'h1000, 16'h0000, 1'b1, 16'h1000, 16'h3000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            get_sample(c, s, cyc, to);
            a = cur_angle();
            total++;
            if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
                bad++; $display("FAIL sweep k=%0d angle=%h got (%0d,%0d) want (%0d,%0d)+-1", k, a, c, s, ref_cos(a), ref_sin(a));
            end
            model_boundary();
        end
    endtask

    task automatic test_backpressure();
        int c, s, cyc, a; bit to;
        start(16'h1000, 16'h0800, 1'b0, '0, '0, 1'b0);
        get_sample(c, s, cyc, to);
        a = cur_angle();
        total++;
        if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
            bad++; $display("FAIL bp_first angle=%h got (%0d,%0d) want (%0d,%0d)+-1", a, c, s, ref_cos(a), ref_sin(a));
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || int'(cos_dout) != c || int'(sin_dout) != s || busy !== 1'b1) begin
                bad++; $display("FAIL bp_hold k=%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", k, dout_valid, cos_dout, sin_dout, c, s);
            end
        end
        dout_ready = 1'b1;
        model_boundary();
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got valid=%b want 0", dout_valid); end
        get_sample(c, s, cyc, to);
        a = cur_angle();
        total++;
        if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
            bad++; $display("FAIL bp_next angle=%h got (%0d,%0d) want (%0d,%0d)+-1", a, c, s, ref_cos(a), ref_sin(a));
        end
        model_boundary();
    endtask

    task automatic test_sync_clr();
        int c, s, cyc, a; bit to;
        start(16'h4000, 16'h0000, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            get_sample(c, s, cyc, to);
            a = cur_angle();
            total++;
            if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
                bad++; $display("FAIL sync k=%0d angle=%h got (%0d,%0d) want (%0d,%0d)+-1", k, a, c, s, ref_cos(a), ref_sin(a));
            end
            if (k == 1) begin
                sync_clr = 1'b1;
                model_boundary();
                @(negedge clk);
                sync_clr = 1'b0;
            end else if (k == 2) begin
                model_boundary();
                repeat (4) @(negedge clk);
                sync_clr = 1'b1;
                @(negedge clk);
                sync_clr = 1'b0;
            end else begin
                model_boundary();
            end
        end
    endtask

    task automatic test_en_drop();
        int c, s, cyc, a; bit to; bit seen;
        start(16'h4000, 16'h0000, 1'b0, '0, '0, 1'b1);
        get_sample(c, s, cyc, to);
        model_boundary();
        @(negedge clk);
        en = 1'b0;
        get_sample(c, s, cyc, to);
        a = cur_angle();
        total++;
        if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
            bad++; $display("FAIL endrop_last angle=%h got (%0d,%0d) want (%0d,%0d)+-1", a, c, s, ref_cos(a), ref_sin(a));
        end
        model_boundary();
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || int'(cos_dout) != c || int'(sin_dout) != s) begin
            bad++; $display("FAIL endrop_idle got v=%b busy=%b (%0d,%0d) want v=0 busy=0 (%0d,%0d)", dout_valid, busy, cos_dout, sin_dout, c, s);
        end
        seen = 1'b0;
        repeat (15) begin @(negedge clk); if (dout_valid) seen = 1'b1; end
        total++;
        if (seen) begin bad++; $display("FAIL endrop_quiet got valid=1 while idle want 0"); end
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        m_acc = 0;
        f_word = 16'h2000;
        en = 1'b1;
        m_freq = 16'h2000;
        for (int k = 0; k < 2; k++) begin
            get_sample(c, s, cyc, to);
            a = cur_angle();
            total++;
            if (to || cyc != ITER + 2 || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
                bad++; $display("FAIL idle_sync k=%0d angle=%h got (%0d,%0d) cyc=%0d want (%0d,%0d)+-1 cyc=%0d", k, a, c, s, cyc, ref_cos(a), ref_sin(a), ITER + 2);
            end
            model_boundary();
        end
    endtask

    task automatic test_rst_mid();
        int c, s, cyc; bit to; bit seen;
        start(16'h1000, 16'h0000, 1'b0, '0, '0, 1'b1);
        repeat (2) begin get_sample(c, s, cyc, to); model_boundary(); end
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1 || dout_valid !== 1'b0) begin bad++; $display("FAIL rst_pre got busy=%b valid=%b want busy=1 valid=0", busy, dout_valid); end
        rst = 1'b1;
        #1;
        total++;
        if (dout_valid !== 1'b0 || sin_dout !== '0 || cos_dout !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid got v=%b sin=%0d cos=%0d busy=%b want all 0", dout_valid, sin_dout, cos_dout, busy);
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (dout_valid || busy) seen = 1'b1; end
        total++;
        if (seen) begin bad++; $display("FAIL rst_after got activity after reset want none"); end
    endtask

    task automatic test_random();
        int c, s, cyc, a, st; bit to;
        start(16'($urandom), 16'($urandom), 1'b1, 16'h0400, 16'h8000, 1'b0);
        for (int k = 0; k < 30; k++) begin
            get_sample(c, s, cyc, to);
            a = cur_angle();
            total++;
            if (to || !near(c, ref_cos(a)) || !near(s, ref_sin(a))) begin
                bad++; $display("FAIL random k=%0d angle=%h got (%0d,%0d) want (%0d,%0d)+-1", k, a, c, s, ref_cos(a), ref_sin(a));
            end
            st = $urandom_range(0, 3);
            for (int j = 0; j < st; j++) begin
                @(negedge clk);
                total++;
                if (dout_valid !== 1'b1 || int'(cos_dout) != c || int'(sin_dout) != s) begin
                    bad++; $display("FAIL random_hold k=%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", k, dout_valid, cos_dout, sin_dout, c, s);
                end
            end
            f_word     = 16'($urandom);
            phase_off  = 16'($urandom);
            sweep_en   = ($urandom_range(0, 3) != 0);
            sweep_step = 16'($urandom_range(0, 16'h3000));
            f_max      = 16'($urandom);
            sync_clr   = ($urandom_range(0, 5) == 0);
            dout_ready = 1'b1;
            model_boundary();
            @(negedge clk);
            dout_ready = 1'b0;
            sync_clr   = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_offset();
        test_sweep();
        test_backpressure();
        test_sync_clr();
        test_en_drop();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
